// File: rtl/switch_box_config_loader.sv
// Serial configuration loader for one switch-box tile.
// Shifts CW bits into a shadow register, commits them to c in one cycle,
// then forwards further bits to the next tile in the chain.
module switch_box_config_loader #(
  parameter int unsigned WS = 8,
  parameter int unsigned WD = 8,
  localparam int unsigned CW = WS * 6 + WD / 2 * 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic          cfg_in_valid,
  input  logic          cfg_in_data,
  output logic          cfg_in_ready,
  output logic          cfg_out_valid,
  output logic          cfg_out_data,
  input  logic          cfg_out_ready,
  output logic [CW-1:0] c,
  output logic          cfg_done
);

  localparam int unsigned CntW = $clog2(CW + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit, StPass} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CW-1:0]   shadow_q;
  logic [CW-1:0]   c_q;
  logic            done_q;
  logic            in_shift;
  logic            in_pass;

  assign in_shift = (state_q == StShift);
  assign in_pass  = (state_q == StPass);

  // Handshake: dropping cfg_en blocks acceptance in the same cycle it aborts.
  assign cfg_in_ready  = (in_shift & cfg_en) | (in_pass & cfg_en & cfg_out_ready);
  assign cfg_out_valid = in_pass & cfg_en & cfg_in_valid;
  assign cfg_out_data  = in_pass & cfg_en & cfg_in_data;

  assign c        = c_q;
  assign cfg_done = done_q;

  // Load FSM: counter, shadow register and committed word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_en) begin
            state_q  <= StShift;
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
          end
        end
        StShift: begin
          if (!cfg_en) begin
            // Abort discards the partial word; c keeps its old value.
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
          end else if (cfg_in_valid) begin
            shadow_q <= {cfg_in_data, shadow_q[CW-1:1]};
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(CW - 1)) begin
              state_q <= StCommit;
            end
          end
        end
        StCommit: begin
          c_q     <= shadow_q;
          done_q  <= 1'b1;
          state_q <= cfg_en ? StPass : StIdle;
        end
        StPass: begin
          if (!cfg_en) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Directed bench for switch_box_config_loader: default (CW=72) and odd (CW=36) tiles.
module tb_switch_box_config_loader;

  logic        clk = 1'b0;
  logic        rst_n, cfg_en, cfg_in_valid, cfg_in_data, cfg_out_ready;
  logic        cfg_in_ready, cfg_out_valid, cfg_out_data, cfg_done;
  logic [71:0] c;
  logic        s_in_ready, s_out_valid, s_out_data, s_done;
  logic [35:0] s_c;

  int n_chk  = 0;
  int n_fail = 0;

  logic [71:0] pat;
  logic [71:0] ones;
  logic [71:0] zero72;

  typedef struct packed {
    logic v;
    logic d;
    logic ordy;
    logic e_rdy;
    logic e_ov;
    logic e_od;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  switch_box_config_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en       (cfg_en),
    .cfg_in_valid (cfg_in_valid),
    .cfg_in_data  (cfg_in_data),
    .cfg_in_ready (cfg_in_ready),
    .cfg_out_valid(cfg_out_valid),
    .cfg_out_data (cfg_out_data),
    .cfg_out_ready(cfg_out_ready),
    .c            (c),
    .cfg_done     (cfg_done)
  );

  switch_box_config_loader #(
    .WS(3),
    .WD(6)
  ) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en       (cfg_en),
    .cfg_in_valid (cfg_in_valid),
    .cfg_in_data  (cfg_in_data),
    .cfg_in_ready (s_in_ready),
    .cfg_out_valid(s_out_valid),
    .cfg_out_data (s_out_data),
    .cfg_out_ready(cfg_out_ready),
    .c            (s_c),
    .cfg_done     (s_done)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Offers bits[from..to-1]; with bub set, random idle cycles are interleaved.
  task automatic stream(input logic [71:0] bits, input int from, input int to, input bit bub);
    int k;
    k = from;
    while (k < to) begin
      if (bub && ($urandom_range(0, 2) == 0)) begin
        cfg_in_valid = 1'b0;
        cfg_in_data  = 1'($urandom);
      end else begin
        cfg_in_valid = 1'b1;
        cfg_in_data  = bits[k];
        k++;
      end
      next();
    end
    cfg_in_valid = 1'b0;
  endtask

  task automatic enter_shift();
    cfg_en       = 1'b0;
    cfg_in_valid = 1'b0;
    next();
    cfg_en = 1'b1;
    next();
    #1;
    chk("entry_done_cleared", cfg_done, 1'b0);
    chk("entry_ready", cfg_in_ready, 1'b1);
  endtask

  // Full 72-bit load from SHIFT, checking that commit happens on exactly bit 72.
  task automatic load72(input logic [71:0] bits, input bit bub, input logic [71:0] prev);
    stream(bits, 0, 71, bub);
    #1;
    chk("pre_last_ready", cfg_in_ready, 1'b1);
    chk("pre_last_c", c, prev);
    stream(bits, 71, 72, bub);
    #1;
    chk("commit_ready", cfg_in_ready, 1'b0);
    chk("commit_c_held", c, prev);
    chk("commit_done", cfg_done, 1'b0);
    next();
    chk("post_c", c, bits);
    chk("post_done", cfg_done, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 72; k++) pat[k] = (k % 3 == 0);
    ones   = '1;
    zero72 = '0;
    // {valid, data, out_ready, exp in_ready, exp out_valid, exp out_data}
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n         = 1'b0;
    cfg_en        = 1'b0;
    cfg_in_valid  = 1'b0;
    cfg_in_data   = 1'b0;
    cfg_out_ready = 1'b0;
    next();
    next();
    #1;
    chk("rst_c", c, zero72);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_ready", cfg_in_ready, 1'b0);
    chk("rst_out_valid", cfg_out_valid, 1'b0);
    chk("rst_out_data", cfg_out_data, 1'b0);
    chk("rst_s_c", s_c, 36'h0);
    chk("rst_s_out_valid", s_out_valid, 1'b0);
    chk("rst_s_out_data", s_out_data, 1'b0);

    // Full load, one bit per cycle; small tile rides on the same stream.
    rst_n  = 1'b1;
    cfg_en = 1'b1;
    #1;
    chk("idle_ready", cfg_in_ready, 1'b0);
    next();
    for (int k = 0; k < 72; k++) begin
      cfg_in_valid = 1'b1;
      cfg_in_data  = pat[k];
      #1;
      if (k == 35) chk("s_ready_35", s_in_ready, 1'b1);
      if (k == 36) begin
        chk("s_commit_ready", s_in_ready, 1'b0);
        chk("s_commit_done", s_done, 1'b0);
        chk("s_commit_c", s_c, 36'h0);
      end
      if (k == 37) begin
        chk("s_c", s_c, pat[35:0]);
        chk("s_done", s_done, 1'b1);
      end
      if (k == 71) begin
        chk("ready_71", cfg_in_ready, 1'b1);
        chk("c_before_commit", c, zero72);
      end
      next();
    end
    cfg_in_valid = 1'b0;
    #1;
    chk("commit_ready", cfg_in_ready, 1'b0);
    chk("commit_c_zero", c, zero72);
    chk("commit_done", cfg_done, 1'b0);
    next();
    chk("full_c", c, pat);
    chk("full_done", cfg_done, 1'b1);

    // Pass-through truth table while in PASS.
    next();
    for (int i = 0; i < 8; i++) begin
      cfg_in_valid  = tbl[i].v;
      cfg_in_data   = tbl[i].d;
      cfg_out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("pass_ready[%0d]", i), cfg_in_ready, tbl[i].e_rdy);
      chk($sformatf("pass_valid[%0d]", i), cfg_out_valid, tbl[i].e_ov);
      chk($sformatf("pass_data[%0d]", i), cfg_out_data, tbl[i].e_od);
      next();
    end
    cfg_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cfg_in_valid = 1'b1;
      cfg_in_data  = 1'($urandom);
      #1;
      chk("pass_mirror", cfg_out_data, cfg_in_data);
      next();
    end
    cfg_in_valid = 1'b0;
    chk("pass_c_kept", c, pat);
    chk("pass_done_kept", cfg_done, 1'b1);

    // Abort after 40 bits, then reload all ones.
    enter_shift();
    stream(ones, 0, 40, 1'b0);
    cfg_en       = 1'b0;
    cfg_in_valid = 1'b1;
    cfg_in_data  = 1'b1;
    #1;
    chk("abort_ready", cfg_in_ready, 1'b0);
    next();
    cfg_in_valid = 1'b0;
    chk("abort_c_kept", c, pat);
    cfg_en = 1'b1;
    next();
    load72(ones, 1'b0, pat);

    // Same pattern with bubbles must give the identical word.
    enter_shift();
    load72(pat, 1'b1, ones);

    // Reset at bit 50 of a load.
    enter_shift();
    stream(ones, 0, 50, 1'b0);
    rst_n        = 1'b0;
    cfg_in_valid = 1'b1;
    next();
    #1;
    chk("rst_shift_c", c, zero72);
    chk("rst_shift_done", cfg_done, 1'b0);
    chk("rst_shift_ready", cfg_in_ready, 1'b0);
    chk("rst_shift_out_valid", cfg_out_valid, 1'b0);
    chk("rst_shift_out_data", cfg_out_data, 1'b0);

    // Reset during the COMMIT cycle suppresses the commit.
    rst_n        = 1'b1;
    cfg_in_valid = 1'b0;
    next();
    stream(ones, 0, 72, 1'b0);
    #1;
    chk("pre_rst_commit_ready", cfg_in_ready, 1'b0);
    rst_n = 1'b0;
    next();
    #1;
    chk("rst_commit_c", c, zero72);
    chk("rst_commit_done", cfg_done, 1'b0);
    chk("rst_commit_ready", cfg_in_ready, 1'b0);
    chk("rst_commit_out_valid", cfg_out_valid, 1'b0);
    rst_n = 1'b1;
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
